sc_program_controller: RTL

- Sequences programming of the DUT scan chain from a serial bit source (the scan-chain bitstream loader or equivalent): generates the scan clock, presents one bitstream bit per scan-clock period, then optionally re-shifts the same bitstream to verify the chain contents at its tail.
- Sits between the host control logic (req/busy/done handshake) and the scan-chain pins of the test board.

---
 rtl/sc_program_controller.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sc_program_controller.sv
// sc_program_controller: clocks a serial bitstream into the test-board scan
// chain, then optionally re-shifts it to verify what comes out of the tail.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for req; sc_cfg_done/error of the last run held
// S_SHIFT  | load pass, one bitstream bit per 2*CLK_DIV clocks
// S_VERIFY | re-shift pass, tail compared against the re-sent bitstream
// S_SETTLE | sc_clk parked low for SETTLE_CYCLES before signalling done
// S_DONE   | done high until req drops
module sc_program_controller #(
   parameter int BITSTREAM_SIZE = 721,
   parameter int CLK_DIV        = 4,
   parameter int SETTLE_CYCLES  = 16,
   parameter bit READBACK_EN    = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_abort,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_error,
   output logic [15:0] o_mismatch_count,
   output logic        o_src_restart,
   output logic        o_src_advance,
   input  logic        i_src_bit,
   output logic        o_sc_head,
   output logic        o_sc_clk,
   input  logic        i_sc_tail,
   output logic        o_sc_cfg_done
);

   localparam int PH_W  = $clog2(2 * CLK_DIV);
   localparam int BIT_W = (BITSTREAM_SIZE > 1) ? $clog2(BITSTREAM_SIZE) : 1;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * CLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(CLK_DIV);
   localparam logic [PH_W-1:0]  PH_CMP   = PH_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITSTREAM_SIZE - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SHIFT,
      S_VERIFY,
      S_SETTLE,
      S_DONE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [PH_W-1:0]  r_phase, w_phase_nxt;
   logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [SET_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
   logic [15:0]      r_mismatch_count, w_mismatch_count_nxt;
   logic             r_error, w_error_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_cfg_done, w_cfg_done_nxt;
   logic             r_sc_head, w_sc_head_nxt;
   logic             r_sc_clk, w_sc_clk_nxt;
   logic             w_restart, w_advance;
   logic             w_head_cur;
   logic             w_shifting_nxt;

   // With CLK_DIV=1 the compare phase is phase 0, before sc_head has been
   // loaded, so compare against the bit that sc_head is about to take.
   assign w_head_cur = (r_phase == '0) ? i_src_bit : r_sc_head;

   // sc_clk is registered from the next phase so the pin never glitches.
   assign w_shifting_nxt = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_VERIFY);
   assign w_sc_clk_nxt   = w_shifting_nxt && (w_phase_nxt >= PH_HIGH);

   // State register and all datapath registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state          <= S_IDLE;
         r_phase          <= '0;
         r_bit_cnt        <= '0;
         r_settle_cnt     <= '0;
         r_mismatch_count <= '0;
         r_error          <= 1'b0;
         r_busy           <= 1'b0;
         r_cfg_done       <= 1'b0;
         r_sc_head        <= 1'b0;
         r_sc_clk         <= 1'b0;
      end else begin
         r_state          <= w_state_nxt;
         r_phase          <= w_phase_nxt;
         r_bit_cnt        <= w_bit_cnt_nxt;
         r_settle_cnt     <= w_settle_cnt_nxt;
         r_mismatch_count <= w_mismatch_count_nxt;
         r_error          <= w_error_nxt;
         r_busy           <= w_busy_nxt;
         r_cfg_done       <= w_cfg_done_nxt;
         r_sc_head        <= w_sc_head_nxt;
         r_sc_clk         <= w_sc_clk_nxt;
      end
   end

   // Next-state, per-phase bit timing and source pulse decode.
   always_comb begin
      w_state_nxt          = r_state;
      w_phase_nxt          = r_phase;
      w_bit_cnt_nxt        = r_bit_cnt;
      w_settle_cnt_nxt     = r_settle_cnt;
      w_mismatch_count_nxt = r_mismatch_count;
      w_error_nxt          = r_error;
      w_busy_nxt           = r_busy;
      w_cfg_done_nxt       = r_cfg_done;
      w_sc_head_nxt        = r_sc_head;
      w_restart            = 1'b0;
      w_advance            = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (i_req && !i_abort) begin
               w_state_nxt          = S_SHIFT;
               w_restart            = 1'b1;
               w_phase_nxt          = '0;
               w_bit_cnt_nxt        = '0;
               w_mismatch_count_nxt = '0;
               w_error_nxt          = 1'b0;
               w_cfg_done_nxt       = 1'b0;
               w_busy_nxt           = 1'b1;
            end
         end
         S_SHIFT, S_VERIFY: begin
            if (i_abort) begin
               w_state_nxt    = S_IDLE;
               w_phase_nxt    = '0;
               w_bit_cnt_nxt  = '0;
               w_busy_nxt     = 1'b0;
               w_error_nxt    = 1'b1;
               w_cfg_done_nxt = 1'b0;
            end else begin
               if (r_phase == '0)
                  w_sc_head_nxt = i_src_bit;
               if ((r_state == S_VERIFY) && (r_phase == PH_CMP) &&
                   (i_sc_tail != w_head_cur) && (r_mismatch_count != 16'hFFFF))
                  w_mismatch_count_nxt = r_mismatch_count + 16'd1;
               if (r_phase == PH_LAST) begin
                  w_phase_nxt = '0;
                  if (r_bit_cnt == BIT_LAST) begin
                     w_bit_cnt_nxt = '0;
                     if ((r_state == S_SHIFT) && READBACK_EN) begin
                        w_restart   = 1'b1;
                        w_state_nxt = S_VERIFY;
                     end else begin
                        w_state_nxt      = S_SETTLE;
                        w_settle_cnt_nxt = '0;
                     end
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                     w_advance     = 1'b1;
                  end
               end else begin
                  w_phase_nxt = r_phase + 1'b1;
               end
            end
         end
         S_SETTLE: begin
            if (i_abort) begin
               w_state_nxt      = S_IDLE;
               w_settle_cnt_nxt = '0;
               w_busy_nxt       = 1'b0;
               w_error_nxt      = 1'b1;
               w_cfg_done_nxt   = 1'b0;
            end else if (r_settle_cnt == SET_LAST) begin
               w_state_nxt      = S_DONE;
               w_settle_cnt_nxt = '0;
               w_cfg_done_nxt   = 1'b1;
               w_busy_nxt       = 1'b0;
               w_error_nxt      = (r_mismatch_count != 16'd0);
            end else begin
               w_settle_cnt_nxt = r_settle_cnt + 1'b1;
            end
         end
         S_DONE: begin
            if (!i_req)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Source pulses are decoded from live inputs; hold them low during reset.
   assign o_src_restart    = w_restart & i_rst_n;
   assign o_src_advance    = w_advance & i_rst_n;
   assign o_busy           = r_busy;
   assign o_done           = (r_state == S_DONE);
   assign o_error          = r_error;
   assign o_mismatch_count = r_mismatch_count;
   assign o_sc_head        = r_sc_head;
   assign o_sc_clk         = r_sc_clk;
   assign o_sc_cfg_done    = r_cfg_done;

endmodule
